muldiv_ctrl: RTL
================

Name: muldiv_ctrl

Overview:
- Sequencing controller for the CPU's HI/LO multiply/divide resource.
- Accepts MULT, MULTU, DIV, DIVU, MTHI and MTLO issues from the execute stage, and owns the architectural HI/LO registers.
- Runs a fixed-latency multiply and a 32-step iterative restoring divide.
- Raises busy so the pipeline stalls any MFHI/MFLO or further mul/div issue until the result is committed.

Parameters:
- MUL_CYCLES, 4, cycles from accepted MULT/MULTU to HI/LO commit; legal range 1..15.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  issue strobe, sampled on rising clk
- funct  input  6  MIPS funct field of the issued R-type instruction
- op1  input  32  rs operand
- op2  input  32  rt operand
- busy  output  1  operation in flight; HI/LO not yet valid
- done  output  1  one-cycle pulse in the cycle HI/LO first show a new mul/div result
- hi  output  32  architectural HI register
- lo  output  32  architectural LO register
- div_zero  output  1  sticky: last DIV/DIVU had op2 == 0; cleared by the next accepted mul/div

Behaviour:
- Reset: rst_n low forces all of the following immediately, regardless of clk, and aborts any in-flight operation with no HI/LO write:
  - state = IDLE, busy = 0, done = 0, div_zero = 0, hi = 0, lo = 0, step counter = 0.
- Recognised funct codes:
  - 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO.
  - start with any other funct is ignored.
- States: IDLE, MUL, DIV, FIX.
- IDLE:
  - start with MTHI/MTLO: hi (resp. lo) <= op1 at that edge. State stays IDLE, busy and done stay 0.
  - start with MULT/MULTU:
    - Latch the 64-bit product: signed for MULT, unsigned for MULTU.
    - Counter <= MUL_CYCLES-1, go to MUL.
  - start with DIV/DIVU:
    - Latch |op1| and |op2| for DIV, or the raw values for DIVU.
    - Latch the quotient and remainder signs.
    - Remainder accumulator <= 0, counter <= 31, go to DIV.
  - Special case MUL_CYCLES = 1: the product commits at the accepting edge and the block stays in IDLE.
- MUL: counter decrements each cycle. At counter == 0, {hi,lo} <= product and state returns to IDLE.
- DIV:
  - One quotient bit per cycle, restoring, MSB first.
  - After 32 steps go to FIX.
- FIX:
  - Negate the quotient if sign(op1) XOR sign(op2), DIV only.
  - Negate the remainder if op1 was negative, DIV only.
  - Commit lo = quotient, hi = remainder, return to IDLE.
- Latency, with the accepting edge counted as edge 0:
  - Multiply commits at edge MUL_CYCLES.
  - Divide commits at edge 34: 32 DIV steps, 1 FIX, with edge 0 loading the operands.
- busy: high from the cycle after the accepting edge up to and including the commit edge; low in the cycle done is high.
- done: high exactly one cycle, immediately after the commit edge. Never asserted for MTHI/MTLO.
- Divide by zero:
  - Takes the full latency.
  - Commits hi = op1 (original value), lo = 32'hFFFFFFFF.
  - Sets div_zero.
- Overflow: DIV of 32'h80000000 by 32'hFFFFFFFF gives lo = 32'h80000000, hi = 0. No flag.
- start while busy: ignored, including MTHI/MTLO. No queue; HI/LO and the in-flight operation are unaffected. The issuing stage is required to stall on busy.
- start in the done cycle: accepted normally; back-to-back operations are allowed.
- Operands are captured at acceptance; later changes to op1/op2/funct do not affect the result.

Test Plan:
1. MULTU op1=32'hFFFFFFFF, op2=2 -> hi=32'h00000001, lo=32'hFFFFFFFE, visible with done after edge 4; busy high for cycles 1-4.
2. MULT op1=-500000000, op2=1000 -> hi=32'hFFFFFF8B, lo=32'h95AD7800; DIVU op1=100, op2=7 -> lo=14, hi=2, done after edge 34.
3. DIV op1=-7, op2=2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF. Then DIV 32'h80000000 / 32'hFFFFFFFF -> lo=32'h80000000, hi=0.
4. DIV op1=5, op2=0 -> hi=5, lo=32'hFFFFFFFF, div_zero=1. Next MULTU 3*3 -> div_zero=0, lo=9, hi=0.
5. MTHI op1=32'hDEADBEEF in IDLE -> hi updates next edge, busy/done stay 0. During a DIV, pulse MTLO op1=1 and MULT 2*2 -> both ignored; DIV result unchanged.
6. Start DIVU 1000/3. Drop rst_n at cycle 10 between clk edges -> busy, hi, lo, done, div_zero read 0 immediately. After release, MULTU 6*7 -> lo=42 at edge MUL_CYCLES.

Source files
------------

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_ctrl
// Purpose  : HI/LO multiply/divide sequencer. It runs a fixed-latency multiply
//            and a 32-step restoring divide, and it owns the architectural
//            HI/LO registers.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
   parameter int MUL_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [5:0]  funct,
   input  logic [31:0] op1,
   input  logic [31:0] op2,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_zero
);

   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [4:0] MUL_LAST = 5'(MUL_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [63:0] prod_q, prod_d;   // product for MUL; original op1 for DIV
   logic [31:0] quo_q, quo_d;     // dividend shifting out, quotient shifting in
   logic [31:0] dvs_q, dvs_d;
   logic [31:0] rem_q, rem_d;
   logic        qneg_q, qneg_d, rneg_q, rneg_d, zero_q, zero_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic        done_q, done_d, divz_q, divz_d;

   logic signed [63:0] w_sa, w_sb;
   logic [63:0]        w_prod_s, w_prod_u, w_prod;
   logic [32:0]        w_shift;
   logic               w_fits;
   logic               w_sgn;

   assign w_sa     = {{32{op1[31]}}, op1};
   assign w_sb     = {{32{op2[31]}}, op2};
   assign w_prod_s = w_sa * w_sb;
   assign w_prod_u = {32'd0, op1} * {32'd0, op2};
   assign w_prod   = (funct == F_MULT) ? w_prod_s : w_prod_u;
   assign w_sgn    = (funct == F_DIV);

   // Partial remainder shifted left with the next dividend bit; the full
   // 33-bit compare avoids a false borrow when the shifted value exceeds 2^32.
   assign w_shift = {rem_q, quo_q[31]};
   assign w_fits  = (w_shift >= {1'b0, dvs_q});

   assign busy     = (state_q != IDLE);
   assign done     = done_q;
   assign hi       = hi_q;
   assign lo       = lo_q;
   assign div_zero = divz_q;

   // Next-state and datapath decisions for the sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      rem_d   = rem_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      zero_d  = zero_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      divz_d  = divz_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               case (funct)
                  F_MTHI: hi_d = op1;
                  F_MTLO: lo_d = op1;
                  F_MULT, F_MULTU: begin
                     divz_d = 1'b0;
                     if (MUL_CYCLES == 1) begin
                        {hi_d, lo_d} = w_prod;
                        done_d       = 1'b1;
                     end else begin
                        prod_d  = w_prod;
                        cnt_d   = MUL_LAST;
                        state_d = MUL;
                     end
                  end
                  F_DIV, F_DIVU: begin
                     divz_d  = 1'b0;
                     quo_d   = (w_sgn && op1[31]) ? (~op1 + 32'd1) : op1;
                     dvs_d   = (w_sgn && op2[31]) ? (~op2 + 32'd1) : op2;
                     qneg_d  = w_sgn && (op1[31] ^ op2[31]);
                     rneg_d  = w_sgn && op1[31];
                     zero_d  = (op2 == 32'd0);
                     prod_d  = {32'd0, op1};
                     rem_d   = 32'd0;
                     cnt_d   = 5'd31;
                     state_d = DIV;
                  end
                  default: ;
               endcase
            end
         end
         MUL: begin
            if (cnt_q == 5'd0) begin
               {hi_d, lo_d} = prod_q;
               done_d       = 1'b1;
               state_d      = IDLE;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         DIV: begin
            rem_d = w_fits ? 32'(w_shift - {1'b0, dvs_q}) : w_shift[31:0];
            quo_d = {quo_q[30:0], w_fits};
            if (cnt_q == 5'd0) begin
               cnt_d   = 5'd1;   // one sign fix-up cycle, then the commit cycle
               state_d = FIX;
            end else begin
               cnt_d = cnt_q - 5'd1;
            end
         end
         FIX: begin
            if (cnt_q != 5'd0) begin
               if (qneg_q) quo_d = ~quo_q + 32'd1;
               if (rneg_q) rem_d = ~rem_q + 32'd1;
               cnt_d = cnt_q - 5'd1;
            end else begin
               if (zero_q) begin
                  hi_d   = prod_q[31:0];
                  lo_d   = 32'hFFFF_FFFF;
                  divz_d = 1'b1;
               end else begin
                  hi_d = rem_q;
                  lo_d = quo_q;
               end
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset aborts any operation in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 5'd0;
         prod_q  <= 64'd0;
         quo_q   <= 32'd0;
         dvs_q   <= 32'd0;
         rem_q   <= 32'd0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         zero_q  <= 1'b0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         done_q  <= 1'b0;
         divz_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         rem_q   <= rem_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         zero_q  <= zero_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
         divz_q  <= divz_d;
      end
   end

endmodule
`default_nettype wire
